// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding-select
// encodings, the in-flight tracker slot record and the slot/forward helpers.
package pipeline_pkg;

    localparam int REG_AW_DEF = 5;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic                  valid;
        logic                  wb_en;
        logic                  mem_rd;
        logic [REG_AW_DEF-1:0] dest;
    } slot_t;

    // Register 0 is hardwired zero, so it never matches an in-flight writer.
    function automatic logic slot_match(input slot_t s,
                                        input logic [REG_AW_DEF-1:0] src,
                                        input logic rd_en);
        return s.valid & s.wb_en & (s.dest == src) & (src != '0) & rd_en;
    endfunction

    function automatic fwd_sel_e fwd_pick(input logic ex_hit,
                                          input logic mem_hit,
                                          input logic ex_is_load);
        if (ex_hit && !ex_is_load) return FWD_EXMEM;
        if (mem_hit)               return FWD_MEMWB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (inc && (count_q != '1))
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_scheduler.sv
// Decode-side hazard controller: stall/bubble/flush decisions, registered
// forwarding selects aligned with EXE, and stall/flush performance counters.
module hazard_scheduler
    import pipeline_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_use_src1,
    input  logic              id_use_src2,
    input  logic              id_wb_en,
    input  logic              id_mem_rd,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              exe_br_taken,
    input  logic              fwd_en,
    input  logic              cnt_clr,
    output logic              stall,
    output logic              bubble,
    output logic              flush,
    output logic [1:0]        fwd_sel_a,
    output logic [1:0]        fwd_sel_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    slot_t    ex_q, ex_d, mem_q, mem_d;
    fwd_sel_e sel_a_q, sel_a_d, sel_b_q, sel_b_d;
    logic     a_ex, a_mem, b_ex, b_mem, hazard;

    always_comb begin
        a_ex  = slot_match(ex_q,  id_src1, id_use_src1);
        a_mem = slot_match(mem_q, id_src1, id_use_src1);
        b_ex  = slot_match(ex_q,  id_src2, id_use_src2);
        b_mem = slot_match(mem_q, id_src2, id_use_src2);

        // With forwarding only a load still in EXE cannot be bypassed in time.
        if (fwd_en)
            hazard = id_valid & (a_ex | b_ex) & ex_q.mem_rd;
        else
            hazard = id_valid & (a_ex | a_mem | b_ex | b_mem);

        flush  = exe_br_taken;
        stall  = ~exe_br_taken & hazard;
        bubble = exe_br_taken | hazard | ~id_valid;

        ex_d = '0;
        if (!bubble) begin
            ex_d.valid  = 1'b1;
            ex_d.wb_en  = id_wb_en;
            ex_d.mem_rd = id_mem_rd;
            ex_d.dest   = id_dest;
        end
        mem_d = ex_q;

        sel_a_d = FWD_RF;
        sel_b_d = FWD_RF;
        if (!bubble && fwd_en) begin
            sel_a_d = fwd_pick(a_ex, a_mem, ex_q.mem_rd);
            sel_b_d = fwd_pick(b_ex, b_mem, ex_q.mem_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q    <= '0;
            mem_q   <= '0;
            sel_a_q <= FWD_RF;
            sel_b_q <= FWD_RF;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
        end
    end

    assign fwd_sel_a = sel_a_q;
    assign fwd_sel_b = sel_b_q;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (stall),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (flush),
        .count (flush_cnt)
    );

endmodule
